// File: rtl/ram_stream_fifo.sv
// ram_stream_fifo: show-ahead valid/ready stream FIFO built on one dualportram
// with a 1-cycle registered read port, plus a 2-entry output register queue
// (head + skid). Sustains one word per clock in and out. Capacity DEPTH+2.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset_n    asynchronous active-low reset
//   flush      synchronous clear of all contents (priority over push/pop)
//   in_data    write word;  in_valid / in_ready  producer handshake
//   out_data   head word;   out_valid / out_ready consumer handshake
//   level      total words held (RAM + in-flight read + output queue)

// Simple dual-port RAM: one write port, one read port with registered output.
module dualportram #(
  parameter int unsigned ADDRBITS  = 9,
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 write_en,
  input  logic [ADDRBITS-1:0]  waddr,
  input  logic [DATAWIDTH-1:0] din,
  input  logic [ADDRBITS-1:0]  raddr,
  output logic [DATAWIDTH-1:0] dout
);
  logic [DATAWIDTH-1:0] mem [0:(1<<ADDRBITS)-1];

  always_ff @(posedge clk) begin
    if (write_en) mem[waddr] <= din;
    dout <= mem[raddr];
  end
endmodule

module ram_stream_fifo #(
  parameter int unsigned ADDRBITS  = 9,
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [DATAWIDTH-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATAWIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDRBITS+1:0]   level
);
  localparam logic [ADDRBITS:0] DEPTH_W = {1'b1, {ADDRBITS{1'b0}}};

  logic [ADDRBITS-1:0]  wptr, rptr;
  logic [ADDRBITS:0]    ram_count, ram_count_n;
  logic                 rd_pending;
  logic [1:0]           out_count, out_count_n;
  logic [DATAWIDTH-1:0] skid;
  logic [DATAWIDTH-1:0] dout;
  logic                 push, pop, issue;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (out_count != 2'd0);

  // Issue a read only if the output queue will have room for it when the
  // RAM word lands: head/skid occupancy plus in-flight read, minus this pop.
  assign issue = (ram_count != '0) &&
                 ((3'(out_count) + 3'(rd_pending)) < (3'd2 + 3'(pop)));

  always_comb begin
    ram_count_n = ram_count;
    if (push && !issue)      ram_count_n = ram_count + (ADDRBITS+1)'(1);
    else if (!push && issue) ram_count_n = ram_count - (ADDRBITS+1)'(1);
  end

  // The issue rule guarantees this never exceeds 2.
  assign out_count_n = 2'(3'(out_count) + 3'(rd_pending) - 3'(pop));

  dualportram #(
    .ADDRBITS (ADDRBITS),
    .DATAWIDTH(DATAWIDTH)
  ) u_ram (
    .clk     (clk),
    .write_en(push),
    .waddr   (wptr),
    .din     (in_data),
    .raddr   (rptr),
    .dout    (dout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      ram_count  <= '0;
      rd_pending <= 1'b0;
      out_count  <= '0;
      out_data   <= '0;
      skid       <= '0;
      in_ready   <= 1'b0;
      level      <= '0;
    end else if (flush) begin
      wptr       <= '0;
      rptr       <= '0;
      ram_count  <= '0;
      rd_pending <= 1'b0;
      out_count  <= '0;
      in_ready   <= 1'b1;
      level      <= '0;
    end else begin
      if (push)  wptr <= wptr + ADDRBITS'(1);
      if (issue) rptr <= rptr + ADDRBITS'(1);
      ram_count  <= ram_count_n;
      rd_pending <= issue;
      out_count  <= out_count_n;
      in_ready   <= (ram_count_n < DEPTH_W);
      level      <= (ADDRBITS+2)'(ram_count_n) + (ADDRBITS+2)'(issue) +
                    (ADDRBITS+2)'(out_count_n);

      // Output queue: skid shifts into head on pop; the landing RAM word
      // fills the first free slot after that shift.
      if (pop) begin
        if (out_count == 2'd2) begin
          out_data <= skid;
          if (rd_pending) skid <= dout;
        end else if (rd_pending) begin
          out_data <= dout;
        end
      end else if (rd_pending) begin
        if (out_count == 2'd0) out_data <= dout;
        else                   skid     <= dout;
      end
    end
  end
endmodule

// File: tb/tb_ram_stream_fifo.sv
module tb_ram_stream_fifo;
  localparam int AB    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AB+1:0] level;

  ram_stream_fifo #(.ADDRBITS(AB), .DATAWIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words still in RAM, and words already fetched toward the
  // output (at most two), each tagged with the cycle it becomes visible.
  typedef struct { logic [DW-1:0] d; int vis; } fent_t;
  logic [DW-1:0] ramq[$];
  fent_t         fq[$];
  fent_t         e;
  int            cyc = 0;
  bit            inrdy_ok = 0;
  bit            acc_last = 0;
  bit            m_valid, m_rdy;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 0);
      ramq.delete();
      fq.delete();
      inrdy_ok = 0;
      acc_last = 0;
    end else begin
      m_valid = (fq.size() > 0) && (fq[0].vis <= cyc);
      m_rdy   = inrdy_ok && (ramq.size() < DEPTH);
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, m_valid);
      chk("level", level, ramq.size() + fq.size());
      if (m_valid) chk("out_data", out_data, fq[0].d);
      if (flush) begin
        ramq.delete();
        fq.delete();
        acc_last = 0;
      end else begin
        if (m_valid && out_ready) void'(fq.pop_front());
        if (ramq.size() > 0 && fq.size() < 2) begin
          e.d   = ramq.pop_front();
          e.vis = cyc + 2;
          fq.push_back(e);
        end
        acc_last = in_valid && m_rdy;
        if (acc_last) ramq.push_back(in_data);
      end
      inrdy_ok = 1;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nxt, last, acc, nacc;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    // Single word latency: push at cycle 0, visible at cycle 3.
    chk("t1_c0_level", level, 0);
    chk("t1_c0_out_valid", out_valid, 0);
    chk("t1_c0_in_ready", in_ready, 1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    step(); in_valid = 1'b0;
    chk("t1_c1_level", level, 1);  chk("t1_c1_out_valid", out_valid, 0);
    step();
    chk("t1_c2_level", level, 1);  chk("t1_c2_out_valid", out_valid, 0);
    step();
    chk("t1_c3_level", level, 1);  chk("t1_c3_out_valid", out_valid, 1);
    chk("t1_c3_out_data", out_data, 8'hA5);
    step();
    chk("t1_c4_level", level, 0);  chk("t1_c4_out_valid", out_valid, 0);

    // Back-to-back streaming: 16 words, no gaps.
    nxt = 0; last = -1;
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin in_valid = 1'b1; in_data = 8'(c); end
      else in_valid = 1'b0;
      if (out_valid) begin
        chk("t2_data", out_data, nxt);
        if (nxt == 0) chk("t2_first_cycle", c, 3);
        else          chk("t2_no_gap", c, last + 1);
        last = c; nxt++;
      end
      step();
    end
    chk("t2_count", nxt, 16);

    // Fill to capacity with no consumer, then drain.
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 25; c++) begin
      in_valid = 1'b1; in_data = 8'(acc);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("t3_accepted", acc, DEPTH + 2);
    chk("t3_full_in_ready", in_ready, 0);
    chk("t3_full_level", level, DEPTH + 2);
    out_ready = 1'b1; nxt = 0;
    for (int c = 0; c < 40; c++) begin
      if (nxt >= DEPTH + 2) break;
      if (c == 0) chk("t3_in_ready_first_pop", in_ready, 0);
      if (c == 1) chk("t3_in_ready_after", in_ready, 1);
      if (out_valid) begin chk("t3_drain_data", out_data, nxt); nxt++; end
      step();
    end
    chk("t3_drained", nxt, DEPTH + 2);

    // Random traffic across pointer wrap; the model checks every cycle.
    nacc = 0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    for (int c = 0; c < 600; c++) begin
      if (in_valid && acc_last) nacc++;
      if (nacc >= 40 && level == 0 && !in_valid) break;
      if (!in_valid || acc_last) begin
        if (nacc < 40) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = DW'($urandom);
        end else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    chk("t4_accepted", nacc, 40);
    chk("t4_drained_level", level, 0);

    // Flush with a read in flight.
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + c);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("t5_level_before_flush", level, 7);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    step();
    flush = 1'b0;
    chk("t5_flush_out_valid", out_valid, 0);
    chk("t5_flush_level", level, 0);
    in_valid = 1'b1; in_data = 8'h3C;
    step(); in_valid = 1'b0;
    step(); step();
    chk("t5_post_valid", out_valid, 1);
    chk("t5_post_data", out_data, 8'h3C);
    step(); step();

    // Asynchronous reset mid-burst.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_data = 8'(8'h60 + c);
      step();
    end
    chk("t6_busy_out_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_out_valid", out_valid, 0);
    chk("t6_async_level", level, 0);
    chk("t6_async_in_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    chk("t6_in_ready_after", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h11;
    step(); in_valid = 1'b0;
    step(); step();
    chk("t6_post_valid", out_valid, 1);
    chk("t6_post_data", out_data, 8'h11);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
